alu_seq_ctrl: RTL and testbench

//  Parametrised successor to the board-level switch/button ALU wrapper. Conditions

---
 rtl/alu_seq_ctrl_pkg.sv | 43 ++++
 rtl/alu_seq_ctrl_if.sv | 31 +++
 rtl/alu_seq_ctrl_btn_conditioner.sv | 76 +++++++
 rtl/alu_seq_ctrl.sv | 177 +++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_ctrl_pkg
// Brief    : Shared constants for the switch/button ALU sequencer: opcode
//            encodings, FSM state encodings, flag bit positions and an
//            opcode-validity helper.
// Revision : 1.0 - initial release
// ============================================================================
package alu_seq_ctrl_pkg;

  // Opcode encodings, taken from i_switch[5:0]
  localparam logic [5:0] c_op_add = 6'b100000;
  localparam logic [5:0] c_op_sub = 6'b100010;
  localparam logic [5:0] c_op_and = 6'b100100;
  localparam logic [5:0] c_op_or  = 6'b100101;
  localparam logic [5:0] c_op_xor = 6'b100110;
  localparam logic [5:0] c_op_sra = 6'b000011;
  localparam logic [5:0] c_op_srl = 6'b000010;
  localparam logic [5:0] c_op_nor = 6'b100111;

  // FSM state encodings (also exported on o_state)
  localparam int         c_st_w   = 2;
  localparam logic [1:0] c_st_a   = 2'b00;
  localparam logic [1:0] c_st_b   = 2'b01;
  localparam logic [1:0] c_st_op  = 2'b10;
  localparam logic [1:0] c_st_run = 2'b11;

  // Bit positions inside o_flags = {overflow, zero, carry}
  localparam int c_flag_carry = 0;
  localparam int c_flag_zero  = 1;
  localparam int c_flag_ovf   = 2;

  // True when the 6-bit code is one of the supported operations
  function automatic logic op_is_valid(input logic [5:0] op);
    case (op)
      c_op_add, c_op_sub, c_op_and, c_op_or,
      c_op_xor, c_op_sra, c_op_srl, c_op_nor: op_is_valid = 1'b1;
      default:                                op_is_valid = 1'b0;
    endcase
  endfunction

endpackage : alu_seq_ctrl_pkg
`default_nettype wire

// File: rtl/alu_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_ctrl_if
// Brief    : Board-side bundle for the ALU sequencer: switches and buttons in,
//            LEDs, flags and status out. master = board side, slave = block.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_seq_ctrl_if
  import alu_seq_ctrl_pkg::*;
#(
  parameter int N_BITS = 8
);
  logic [N_BITS-1:0] i_switch;
  logic [2:0]        i_boton;
  logic [N_BITS-1:0] o_leds;
  logic [2:0]        o_flags;
  logic              o_valid;
  logic              o_err;
  logic [c_st_w-1:0] o_state;

  modport master (
    output i_switch, i_boton,
    input  o_leds, o_flags, o_valid, o_err, o_state
  );

  modport slave (
    input  i_switch, i_boton,
    output o_leds, o_flags, o_valid, o_err, o_state
  );
endinterface : alu_seq_ctrl_if
`default_nettype wire

// File: rtl/alu_seq_ctrl_btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_ctrl_btn_conditioner
// Brief    : One push-button: 2-FF synchroniser, optional counter debouncer,
//            rising-edge detector producing a single-cycle pulse.
//            Optional feature macro: ALU_DEBOUNCE_EN (debouncer built only
//            when defined; DB_CYCLES is otherwise ignored).
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl_btn_conditioner #(
  parameter int DB_CYCLES = 4
) (
  input  wire logic i_clock,
  input  wire logic i_reset,
  input  wire logic i_btn,
  output logic      o_pulse
);

  logic r_sync0;
  logic r_sync1;
  logic r_prev;
  logic r_pulse;
  logic w_level;

  // Two-flop synchroniser for the asynchronous button input
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
    end else begin
      r_sync0 <= i_btn;
      r_sync1 <= r_sync0;
    end
  end

`ifdef ALU_DEBOUNCE_EN
  localparam int c_cnt_w = $clog2(DB_CYCLES + 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic               r_stable;

  // Accept a new level only after DB_CYCLES consecutive differing samples
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (r_sync1 == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt == c_cnt_w'(DB_CYCLES - 1)) begin
      r_stable <= r_sync1;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_level = r_stable;
`else
  assign w_level = r_sync1;
`endif

  // Registered rising-edge detect: a held button yields exactly one pulse
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_prev  <= w_level;
      r_pulse <= w_level & ~r_prev;
    end
  end

  assign o_pulse = r_pulse;

endmodule : alu_seq_ctrl_btn_conditioner
`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_ctrl
// Brief    : Button-sequenced ALU wrapper. Loads A, B and opcode from the
//            switches under FSM control, runs a combinational ALU and
//            registers result and {overflow, zero, carry} onto the LEDs.
//            Optional feature macro: ALU_DEBOUNCE_EN (button debouncing).
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter int N_BITS    = 8,
  parameter int DB_CYCLES = 4
) (
  input  wire logic     i_clock,
  input  wire logic     i_reset,
  alu_seq_ctrl_if.slave bus
);

  logic [2:0]        w_pulse;
  logic              w_pa;
  logic              w_pb;
  logic              w_pop;
  logic [5:0]        w_sw_op;
  logic              w_op_ok;

  logic [N_BITS-1:0] r_a;
  logic [N_BITS-1:0] r_b;
  logic [5:0]        r_op;
  logic [c_st_w-1:0] r_state;
  logic              r_err;

  logic [N_BITS-1:0] r_leds;
  logic [2:0]        r_flags;
  logic              r_valid;

  logic [N_BITS:0]   w_sum;
  logic [N_BITS:0]   w_diff;
  logic [N_BITS-1:0] w_res;
  logic [2:0]        w_flags;

  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    alu_seq_ctrl_btn_conditioner #(
      .DB_CYCLES (DB_CYCLES)
    ) u_btn (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_btn   (bus.i_boton[gi]),
      .o_pulse (w_pulse[gi])
    );
  end

  // Same-cycle pulses resolve as A over B over opcode
  assign w_pa    = w_pulse[0];
  assign w_pb    = w_pulse[1] & ~w_pulse[0];
  assign w_pop   = w_pulse[2] & ~w_pulse[1] & ~w_pulse[0];
  assign w_sw_op = bus.i_switch[5:0];
  assign w_op_ok = op_is_valid(w_sw_op);

  // Load sequencer: operand/opcode registers follow the FSM transitions
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_err   <= 1'b0;
      r_state <= c_st_a;
    end else begin
      case (r_state)
        c_st_a: begin
          if (w_pa) begin
            r_a     <= bus.i_switch;
            r_state <= c_st_b;
          end
        end
        c_st_b: begin
          if (w_pa) begin
            r_a <= bus.i_switch;
          end else if (w_pb) begin
            r_b     <= bus.i_switch;
            r_state <= c_st_op;
          end
        end
        c_st_op: begin
          if (w_pa) begin
            r_a     <= bus.i_switch;
            r_state <= c_st_b;
          end else if (w_pop) begin
            if (w_op_ok) begin
              r_op    <= w_sw_op;
              r_err   <= 1'b0;
              r_state <= c_st_run;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        default: begin
          if (w_pa) begin
            r_a     <= bus.i_switch;
            r_state <= c_st_b;
          end else if (w_pb) begin
            r_b <= bus.i_switch;
          end else if (w_pop) begin
            if (w_op_ok) begin
              r_op  <= w_sw_op;
              r_err <= 1'b0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff = {1'b0, r_a} - {1'b0, r_b};

  // Combinational ALU; the top bit of w_diff is the unsigned borrow
  always_comb begin
    w_res   = '0;
    w_flags = '0;
    case (r_op)
      c_op_add: begin
        w_res                 = w_sum[N_BITS-1:0];
        w_flags[c_flag_carry] = w_sum[N_BITS];
        w_flags[c_flag_ovf]   = (r_a[N_BITS-1] == r_b[N_BITS-1]) &&
                                (w_res[N_BITS-1] != r_a[N_BITS-1]);
      end
      c_op_sub: begin
        w_res                 = w_diff[N_BITS-1:0];
        w_flags[c_flag_carry] = w_diff[N_BITS];
        w_flags[c_flag_ovf]   = (r_a[N_BITS-1] != r_b[N_BITS-1]) &&
                                (w_res[N_BITS-1] != r_a[N_BITS-1]);
      end
      c_op_and: w_res = r_a & r_b;
      c_op_or:  w_res = r_a | r_b;
      c_op_xor: w_res = r_a ^ r_b;
      c_op_nor: w_res = ~(r_a | r_b);
      c_op_srl: begin
        if (r_b >= N_BITS'(N_BITS)) w_res = '0;
        else                        w_res = r_a >> r_b;
      end
      c_op_sra: begin
        if (r_b >= N_BITS'(N_BITS)) w_res = {N_BITS{r_a[N_BITS-1]}};
        else                        w_res = $unsigned($signed(r_a) >>> r_b);
      end
      default: w_res = '0;
    endcase
    w_flags[c_flag_zero] = (w_res == '0);
  end

  // Output registers: refresh only while running, otherwise hold
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_leds  <= '0;
      r_flags <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= (r_state == c_st_run);
      if (r_state == c_st_run) begin
        r_leds  <= w_res;
        r_flags <= w_flags;
      end
    end
  end

  assign bus.o_leds  = r_leds;
  assign bus.o_flags = r_flags;
  assign bus.o_valid = r_valid;
  assign bus.o_err   = r_err;
  assign bus.o_state = r_state;

endmodule : alu_seq_ctrl
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq_ctrl
// Brief    : Directed self-checking bench for alu_seq_ctrl (N_BITS = 8).
//            Honours ALU_DEBOUNCE_EN for the glitch-rejection step.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq_ctrl;

  localparam int N      = 8;
  localparam int HOLD   = 12;
  localparam int SETTLE = 12;

  localparam logic [7:0] OP_ADD = 8'h20;
  localparam logic [7:0] OP_SUB = 8'h22;
  localparam logic [7:0] OP_AND = 8'h24;
  localparam logic [7:0] OP_SRA = 8'h03;
  localparam logic [7:0] OP_SRL = 8'h02;
  localparam logic [7:0] OP_NOR = 8'h27;
  localparam logic [7:0] OP_BAD = 8'h3F;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_seq_ctrl_if #(.N_BITS(N)) bus ();

  alu_seq_ctrl #(
    .N_BITS    (N),
    .DB_CYCLES (4)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic [7:0] leds;
    logic [2:0] flags;
  } exp_t;

  exp_t sb[$];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [2:0] mask, input logic [7:0] sw);
    bus.i_switch = sw;
    bus.i_boton  = mask;
    tick(HOLD);
    bus.i_boton  = 3'b000;
    tick(SETTLE);
  endtask

  task automatic push(input string tag, input logic [7:0] l, input logic [2:0] f);
    exp_t e;
    e.tag   = tag;
    e.leds  = l;
    e.flags = f;
    sb.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    int   k;
    k = 0;
    while (bus.o_valid !== 1'b1 && k < 40) begin
      tick(1);
      k++;
    end
    total++;
    assert (sb.size() > 0)
    else begin
      bad++;
      $error("FAIL sb_underflow observed=0 expected=1");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, "_valid"}, 32'(bus.o_valid), 32'd1);
      chk({e.tag, "_leds"},  32'(bus.o_leds),  32'(e.leds));
      chk({e.tag, "_flags"}, 32'(bus.o_flags), 32'(e.flags));
    end
  endtask

  initial begin
    bus.i_switch = '0;
    bus.i_boton  = 3'b000;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
    chk("rst_leds",  32'(bus.o_leds),  32'h00);
    chk("rst_flags", 32'(bus.o_flags), 32'h0);
    chk("rst_valid", 32'(bus.o_valid), 32'h0);
    chk("rst_err",   32'(bus.o_err),   32'h0);
    chk("rst_state", 32'(bus.o_state), 32'h0);

    // 0x7F + 0x01: signed overflow, no carry
    press(3'b001, 8'h7F);
    chk("t1_state_b", 32'(bus.o_state), 32'h1);
    press(3'b010, 8'h01);
    chk("t1_state_op", 32'(bus.o_state), 32'h2);
    chk("t1_valid_lo", 32'(bus.o_valid), 32'h0);
    push("t1_add", 8'h80, 3'b100);
    press(3'b100, OP_ADD);
    sb_check();
    chk("t1_state_run", 32'(bus.o_state), 32'h3);

    // Reload B while running, then SUB
    press(3'b010, 8'h7F);
    push("t2_add_7f", 8'hFE, 3'b100);
    sb_check();
    push("t2_sub_zero", 8'h00, 3'b010);
    press(3'b100, OP_SUB);
    sb_check();
    push("t2_sub_borrow", 8'hFF, 3'b101);
    press(3'b010, 8'h80);
    sb_check();

    // Shifts and NOR on A=0x90
    press(3'b001, 8'h90);
    press(3'b010, 8'h02);
    push("t3_sra", 8'hE4, 3'b000);
    press(3'b100, OP_SRA);
    sb_check();
    push("t3_srl", 8'h24, 3'b000);
    press(3'b100, OP_SRL);
    sb_check();
    push("t3_nor", 8'h6D, 3'b000);
    press(3'b100, OP_NOR);
    sb_check();
    push("t3_nor_b9", 8'h66, 3'b000);
    press(3'b010, 8'h09);
    sb_check();
    push("t3_sra_big", 8'hFF, 3'b000);
    press(3'b100, OP_SRA);
    sb_check();
    push("t3_srl_big", 8'h00, 3'b010);
    press(3'b100, OP_SRL);
    sb_check();

    // Unsupported opcode in ST_OP
    press(3'b001, 8'h90);
    chk("t4_valid_drop", 32'(bus.o_valid), 32'h0);
    press(3'b010, 8'h09);
    press(3'b100, OP_BAD);
    chk("t4_err_set",   32'(bus.o_err),   32'h1);
    chk("t4_state_op",  32'(bus.o_state), 32'h2);
    chk("t4_valid_lo",  32'(bus.o_valid), 32'h0);
    push("t4_and", 8'h00, 3'b010);
    press(3'b100, OP_AND);
    sb_check();
    chk("t4_err_clr", 32'(bus.o_err), 32'h0);

    // A and B buttons together while running: A wins
    press(3'b011, 8'h55);
    chk("t5_state_b",   32'(bus.o_state), 32'h1);
    chk("t5_valid_lo",  32'(bus.o_valid), 32'h0);
    chk("t5_leds_hold", 32'(bus.o_leds),  32'h00);
    press(3'b010, 8'h00);
    push("t5_a_loaded", 8'h55, 3'b000);
    press(3'b100, OP_ADD);
    sb_check();

    // Asynchronous reset in the middle of a sequence
    press(3'b001, 8'h11);
    chk("t6_state_b", 32'(bus.o_state), 32'h1);
    rst = 1'b1;
    #2;
    chk("t6_async_state", 32'(bus.o_state), 32'h0);
    chk("t6_async_leds",  32'(bus.o_leds),  32'h00);
    tick(1);
    rst = 1'b0;
    tick(1);
    chk("t6_flags", 32'(bus.o_flags), 32'h0);
    chk("t6_valid", 32'(bus.o_valid), 32'h0);
    chk("t6_err",   32'(bus.o_err),   32'h0);
    press(3'b010, 8'hAA);
    chk("t6_b_ignored", 32'(bus.o_state), 32'h0);

`ifdef ALU_DEBOUNCE_EN
    bus.i_switch = 8'h33;
    bus.i_boton  = 3'b001;
    tick(2);
    bus.i_boton  = 3'b000;
    tick(SETTLE);
    chk("t6_glitch_state", 32'(bus.o_state), 32'h0);
`endif

    // Fresh sequence after reset
    press(3'b001, 8'h01);
    press(3'b010, 8'h01);
    push("t6_post_add", 8'h02, 3'b000);
    press(3'b100, OP_ADD);
    sb_check();

    total++;
    assert (sb.size() == 0)
    else begin
      bad++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_alu_seq_ctrl
`default_nettype wire
